// File: rtl/axi_stream_wr_burst_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : axi_stream_wr_burst_if                                    |
// | Purpose  : Bundles the stream input, AXI4 AW/W/B write channels and  |
// |            status signals of axi_stream_wr_burst.                    |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface axi_stream_wr_burst_if #(
  parameter int AW = 26,
  parameter int DW = 16
);
  // control
  logic          i_clear;
  // stream in
  logic          i_tvalid;
  logic          o_tready;
  logic [DW-1:0] i_tdata;
  // AXI write address
  logic          o_awvalid;
  logic          i_awready;
  logic [AW-1:0] o_awaddr;
  logic [7:0]    o_awlen;
  // AXI write data
  logic          o_wvalid;
  logic          i_wready;
  logic          o_wlast;
  logic [DW-1:0] o_wdata;
  // AXI write response
  logic          i_bvalid;
  logic          o_bready;
  // status
  logic          o_region_full;
  logic [15:0]   o_burst_cnt;

  // The block itself is the AXI write master, so it takes the master view.
  modport master (
    input  i_clear, i_tvalid, i_tdata, i_awready, i_wready, i_bvalid,
    output o_tready, o_awvalid, o_awaddr, o_awlen, o_wvalid, o_wlast,
           o_wdata, o_bready, o_region_full, o_burst_cnt
  );

  // Stream producer / memory controller side.
  modport slave (
    output i_clear, i_tvalid, i_tdata, i_awready, i_wready, i_bvalid,
    input  o_tready, o_awvalid, o_awaddr, o_awlen, o_wvalid, o_wlast,
           o_wdata, o_bready, o_region_full, o_burst_cnt
  );
endinterface
`default_nettype wire

// File: rtl/axi_stream_wr_burst.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : axi_stream_wr_burst                                       |
// | Purpose  : Buffers a valid/ready stream in a FIFO and writes it into |
// |            a circular DDR region with fixed-length AXI4 INCR bursts. |
// | Options  : WR_BURST_WRAP_EN - offset wraps to the region start;      |
// |            when undefined the block stops at the region end and     |
// |            raises o_region_full until cleared.                      |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module axi_stream_wr_burst #(
  parameter int            AW          = 26,
  parameter int            D_LEVEL     = 1,
  parameter int            DW          = 16,
  parameter logic [7:0]    BURST_LEN   = 8'd7,
  parameter int            FIFO_LOG2   = 5,
  parameter logic [AW-1:0] BASE_ADDR   = '0,
  parameter int            REGION_LOG2 = 12
) (
  input wire clk,
  input wire rst_n,
  axi_stream_wr_burst_if.master bus
);

  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam logic [FIFO_LOG2:0] FIFO_FULL_LVL = (FIFO_LOG2+1)'(DEPTH);
  // A burst is only launched once every beat of it is already buffered,
  // so W never has to stall on an empty FIFO.
  localparam logic [FIFO_LOG2:0] LAUNCH_LVL = (FIFO_LOG2+1)'(int'(BURST_LEN) + 1);
  // Bytes covered by one burst; one extra bit so a full-region step fits.
  localparam logic [REGION_LOG2:0] BURST_BYTES =
    (REGION_LOG2+1)'((int'(BURST_LEN) + 1) << D_LEVEL);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AW   = 2'd1,
    S_W    = 2'd2,
    S_B    = 2'd3
  } state_t;

  // ---------------------------------------------------------------------
  // FIFO storage and occupancy
  // ---------------------------------------------------------------------
  logic [DW-1:0]        mem [DEPTH];
  logic [FIFO_LOG2-1:0] wr_ptr;
  logic [FIFO_LOG2-1:0] rd_ptr;
  logic [FIFO_LOG2:0]   count;
  logic                 tready;
  logic                 push;
  logic                 pop;

  // ---------------------------------------------------------------------
  // Burst engine registers
  // ---------------------------------------------------------------------
  state_t                 state;
  logic                   awvalid;
  logic [AW-1:0]          awaddr;
  logic                   wvalid;
  logic                   bready;
  logic [7:0]             beat;
  logic [REGION_LOG2-1:0] offset;
  logic                   region_full;
  logic [15:0]            burst_cnt;
  logic                   clear_pending;

  logic [REGION_LOG2-1:0] offset_next;
  logic                   region_overflow;
  logic [AW-1:0]          launch_addr;

  assign tready = (count != FIFO_FULL_LVL);
  assign push   = bus.i_tvalid & tready;
  // wvalid is only high in S_W, so stray wready pulses never pop.
  assign pop    = wvalid & bus.i_wready;

`ifdef WR_BURST_WRAP_EN
  // Natural modulo-2^REGION_LOG2 arithmetic gives the wrap for free.
  assign offset_next     = offset + BURST_BYTES[REGION_LOG2-1:0];
  assign region_overflow = 1'b0;
`else
  // The carry out of the region-sized add flags the end of the region.
  logic [REGION_LOG2:0] offset_sum;
  assign offset_sum      = {1'b0, offset} + BURST_BYTES;
  assign offset_next     = offset_sum[REGION_LOG2-1:0];
  assign region_overflow = offset_sum[REGION_LOG2];
`endif

  // Base is aligned to the region size, so OR-ing in the offset is an add.
  assign launch_addr = BASE_ADDR | AW'(offset);

  // Write port of the FIFO storage; data needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.i_tdata;
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop keeps count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Burst sequencer: launch, address phase, data phase, response, with
  // offset/region bookkeeping and deferred clear handling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      awvalid       <= 1'b0;
      awaddr        <= BASE_ADDR;
      wvalid        <= 1'b0;
      bready        <= 1'b0;
      beat          <= 8'd0;
      offset        <= '0;
      region_full   <= 1'b0;
      burst_cnt     <= 16'd0;
      clear_pending <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // A clear in idle wins over a launch in the same cycle, so the
          // next burst always starts from the rewound offset.
          if (bus.i_clear) begin
            offset      <= '0;
            region_full <= 1'b0;
          end else if ((count >= LAUNCH_LVL) && !region_full) begin
            awvalid <= 1'b1;
            awaddr  <= launch_addr;
            state   <= S_AW;
          end
        end

        S_AW: begin
          if (bus.i_clear) begin
            clear_pending <= 1'b1;
          end
          if (bus.i_awready) begin
            awvalid <= 1'b0;
            wvalid  <= 1'b1;
            beat    <= 8'd0;
            state   <= S_W;
          end
        end

        S_W: begin
          if (bus.i_clear) begin
            clear_pending <= 1'b1;
          end
          if (bus.i_wready) begin
            if (beat == BURST_LEN) begin
              wvalid <= 1'b0;
              bready <= 1'b1;
              state  <= S_B;
            end else begin
              beat <= beat + 8'd1;
            end
          end
        end

        S_B: begin
          if (bus.i_bvalid) begin
            bready        <= 1'b0;
            burst_cnt     <= burst_cnt + 16'd1;
            clear_pending <= 1'b0;
            state         <= S_IDLE;
            // A clear seen during the burst replaces the normal advance.
            if (clear_pending || bus.i_clear) begin
              offset      <= '0;
              region_full <= 1'b0;
            end else if (region_overflow) begin
              region_full <= 1'b1;
            end else begin
              offset <= offset_next;
            end
          end else if (bus.i_clear) begin
            clear_pending <= 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_tready      = tready;
  assign bus.o_awvalid     = awvalid;
  assign bus.o_awaddr      = awaddr;
  assign bus.o_awlen       = BURST_LEN;
  assign bus.o_wvalid      = wvalid;
  assign bus.o_wlast       = wvalid & (beat == BURST_LEN);
  assign bus.o_wdata       = mem[rd_ptr];
  assign bus.o_bready      = bready;
  assign bus.o_region_full = region_full;
  assign bus.o_burst_cnt   = burst_cnt;

endmodule
`default_nettype wire

// File: tb/tb_axi_stream_wr_burst.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_axi_stream_wr_burst                                    |
// | Purpose  : Randomised self-checking bench for axi_stream_wr_burst   |
// |            with a queue-based reference model of the write path.    |
// | Options  : WR_BURST_WRAP_EN selects the wrapping-region expectations |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_axi_stream_wr_burst;

  localparam int AW          = 26;
  localparam int DW          = 16;
  localparam int REGION_LOG2 = 5;
  localparam int REGION      = 1 << REGION_LOG2;
  localparam int BEATS       = 8;
  localparam int BURST_BYTES = BEATS * 2;
  localparam int DEPTH       = 32;
`ifdef WR_BURST_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_stream_wr_burst_if #(.AW(AW), .DW(DW)) bus ();

  axi_stream_wr_burst #(
    .AW(AW), .D_LEVEL(1), .DW(DW), .BURST_LEN(8'd7), .FIFO_LOG2(5),
    .BASE_ADDR(26'h0), .REGION_LOG2(REGION_LOG2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.master)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // stimulus controls
  logic [DW-1:0] src_q[$];
  int  src_rate  = 100;
  int  aw_rate   = 100;
  int  w_rate    = 100;
  int  b_rate    = 100;
  int  w_mode    = 0;   // 0 random, 1 toggle, 2 held low
  int  aw_stall  = 0;
  bit  t_hs      = 1'b0;

  // reference model state
  logic [DW-1:0] m_q[$];
  logic [AW-1:0] aw_log[$];
  int  m_off      = 0;
  bit  m_full     = 1'b0;
  bit  m_clr_pend = 1'b0;
  int  m_cnt      = 0;
  bit  m_aw_done  = 1'b0;
  bit  m_aw_wait  = 1'b0;
  int  m_beat     = 0;
  int  n_launch   = 0;
  int  n_acc      = 0;
  int  aw_wait_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1 bus.i_clear = 1'b1;
    @(posedge clk); #1 bus.i_clear = 1'b0;
  endtask

  function automatic bit dut_idle();
    return !bus.o_awvalid && !bus.o_wvalid && !bus.o_bready;
  endfunction

  task automatic wait_drained(input int budget, input bit auto_clear);
    int  n;
    bit  done;
    n = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      @(negedge clk); #1;
      n++;
      done = (src_q.size() == 0) && !bus.i_tvalid && (m_q.size() == 0) && dut_idle();
      if (!done && auto_clear && m_full && dut_idle()) begin
        pulse_clear();
        n += 2;
      end
    end
    check("drain_done", done, 1'b1);
  endtask

  // Stream source: presents queued words, holds each until accepted.
  initial begin
    bus.i_tvalid = 1'b0;
    bus.i_tdata  = '0;
    forever begin
      @(posedge clk); #1;
      if (!bus.i_tvalid || t_hs) begin
        if (src_q.size() > 0 && $urandom_range(99) < src_rate) begin
          bus.i_tvalid = 1'b1;
          bus.i_tdata  = src_q.pop_front();
        end else begin
          bus.i_tvalid = 1'b0;
          bus.i_tdata  = '0;
        end
      end
    end
  end

  // AXI slave responder with random or scripted ready/valid patterns.
  initial begin
    bus.i_awready = 1'b0;
    bus.i_wready  = 1'b0;
    bus.i_bvalid  = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (aw_stall > 0) begin
        bus.i_awready = 1'b0;
        if (bus.o_awvalid) aw_stall--;
      end else begin
        bus.i_awready = ($urandom_range(99) < aw_rate);
      end
      case (w_mode)
        1:       bus.i_wready = !bus.i_wready;
        2:       bus.i_wready = 1'b0;
        default: bus.i_wready = ($urandom_range(99) < w_rate);
      endcase
      bus.i_bvalid = ($urandom_range(99) < b_rate);
    end
  end

  // Reference model and per-cycle protocol checks.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("tready", bus.o_tready, m_q.size() != DEPTH);
        check("awlen", bus.o_awlen, 8'd7);
        check("burst_cnt", bus.o_burst_cnt, m_cnt);
        check("region_full", bus.o_region_full, m_full);
        check("wlast", bus.o_wlast, bus.o_wvalid && (m_beat == BEATS - 1));
        check("w_before_aw", bus.o_wvalid && !m_aw_done, 1'b0);
        if (m_aw_wait) check("aw_hold", bus.o_awvalid, 1'b1);
        if (bus.o_awvalid) begin
          check("awaddr", bus.o_awaddr, m_off);
          if (!m_aw_wait) begin
            n_launch++;
            check("launch_while_full", m_full, 1'b0);
            check("launch_level", m_q.size() >= BEATS, 1'b1);
          end
          if (!bus.i_awready) begin
            aw_wait_cnt++;
          end else begin
            m_aw_done = 1'b1;
            m_beat    = 0;
            aw_log.push_back(bus.o_awaddr);
          end
        end
        m_aw_wait = bus.o_awvalid && !bus.i_awready;

        if (bus.o_wvalid && bus.i_wready) begin
          check("w_nonempty", m_q.size() > 0, 1'b1);
          if (m_q.size() > 0) check("wdata", bus.o_wdata, m_q.pop_front());
          m_beat++;
          if (m_beat == BEATS) begin
            m_beat    = 0;
            m_aw_done = 1'b0;
          end
        end

        if (bus.i_clear) begin
          if (!dut_idle()) m_clr_pend = 1'b1;
          else begin
            m_off  = 0;
            m_full = 1'b0;
          end
        end

        if (bus.o_bready && bus.i_bvalid) begin
          m_cnt = (m_cnt + 1) % 65536;
          if (m_clr_pend) begin
            m_off      = 0;
            m_full     = 1'b0;
            m_clr_pend = 1'b0;
          end else if (m_off + BURST_BYTES >= REGION) begin
            if (WRAP) m_off = m_off + BURST_BYTES - REGION;
            else      m_full = 1'b1;
          end else begin
            m_off = m_off + BURST_BYTES;
          end
        end

        t_hs = bus.i_tvalid && bus.o_tready;
        if (t_hs) begin
          m_q.push_back(bus.i_tdata);
          n_acc++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    bit ok;
    int cnt0;
    int l0;
    int acc0;
    int k;
    bus.i_clear = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_awvalid", bus.o_awvalid, 1'b0);
    check("rst_wvalid", bus.o_wvalid, 1'b0);
    check("rst_wlast", bus.o_wlast, 1'b0);
    check("rst_bready", bus.o_bready, 1'b0);
    check("rst_awaddr", bus.o_awaddr, 26'h0);
    check("rst_region_full", bus.o_region_full, 1'b0);
    check("rst_burst_cnt", bus.o_burst_cnt, 16'd0);
    check("rst_tready", bus.o_tready, 1'b1);
    check("rst_awlen", bus.o_awlen, 8'd7);
    @(posedge clk); #1 rst_n = 1'b1;

    // single burst, everything immediately ready
    for (int i = 1; i <= 8; i++) src_q.push_back(16'(i));
    wait_drained(400, 1'b0);
    check("t1_burst_cnt", bus.o_burst_cnt, 16'd1);
    check("t1_awaddr", aw_log[0], 26'h0);

    // awready held low for five cycles of awvalid
    aw_wait_cnt = 0;
    aw_stall = 5;
    for (int i = 0; i < 8; i++) src_q.push_back(16'h0100 + 16'(i));
    wait_drained(400, 1'b0);
    check("t2_aw_wait", aw_wait_cnt, 5);
    check("t2_awaddr", aw_log[1], 26'h10);
    check("t2_region_full", bus.o_region_full, !WRAP);
    pulse_clear();

    // toggling wready, two bursts
    w_mode = 1;
    for (int i = 0; i < 16; i++) src_q.push_back(16'($urandom));
    wait_drained(600, 1'b0);
    k = aw_log.size();
    check("t3_addr0", aw_log[k-2], 26'h0);
    check("t3_addr1", aw_log[k-1], 26'h10);
    w_mode = 0;
    pulse_clear();

    // 48 words into a two-burst region under random back-pressure
    src_rate = 80; aw_rate = 70; w_rate = 60; b_rate = 50;
    cnt0 = m_cnt; l0 = n_launch;
    for (int i = 0; i < 48; i++) src_q.push_back(16'($urandom));
    n = 0; ok = 1'b0;
    while (!ok && n < 2000) begin
      @(negedge clk); #1;
      n++;
      ok = ((m_cnt - cnt0) >= 2) && dut_idle();
    end
    check("t4_two_bursts", ok, 1'b1);
    repeat (60) @(negedge clk);
    check("t4_region_full", bus.o_region_full, !WRAP);
    check("t4_third_launch", (n_launch - l0) > 2, WRAP);
    wait_drained(4000, 1'b1);
    src_rate = 100; aw_rate = 100; w_rate = 100; b_rate = 100;

    // clear during the data phase of the burst at 0x10
    pulse_clear();
    for (int i = 0; i < 16; i++) src_q.push_back(16'($urandom));
    n = 0; ok = 1'b0;
    while (!ok && n < 400) begin
      @(negedge clk); #1;
      n++;
      ok = bus.o_wvalid && (bus.o_awaddr == 26'h10);
    end
    check("t5_saw_w_at_10", ok, 1'b1);
    pulse_clear();
    for (int i = 0; i < 8; i++) src_q.push_back(16'($urandom));
    wait_drained(600, 1'b0);
    k = aw_log.size();
    check("t5_addr0", aw_log[k-3], 26'h0);
    check("t5_addr1", aw_log[k-2], 26'h10);
    check("t5_addr2", aw_log[k-1], 26'h0);

    // stalled W channel: FIFO fills to exactly 32 and stops accepting
    pulse_clear();
    w_mode = 2;
    acc0 = n_acc;
    for (int i = 0; i < 40; i++) src_q.push_back(16'($urandom));
    repeat (100) @(negedge clk);
    #1;
    check("t6_tready", bus.o_tready, 1'b0);
    check("t6_accepted", n_acc - acc0, 32);
    w_mode = 0;
    wait_drained(4000, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
